// File: rtl/sm3_msg_arb.sv
// Message-level round-robin arbiter in front of the SM3 pad/compress chain.
// One requester owns the datapath from first beat until hash_done_i closes its message.
module sm3_msg_arb #(
    parameter int N_REQ = 2,
    parameter int DW    = 32,
    localparam int BW   = DW / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ*DW-1:0]   req_d_i,
    input  logic [N_REQ*BW-1:0]   req_vld_byte_i,
    input  logic [N_REQ-1:0]      req_vld_i,
    input  logic [N_REQ-1:0]      req_lst_i,
    output logic [N_REQ-1:0]      req_rdy_o,
    output logic [DW-1:0]         dn_d_o,
    output logic [BW-1:0]         dn_vld_byte_o,
    output logic                  dn_vld_o,
    output logic                  dn_lst_o,
    input  logic                  dn_rdy_i,
    input  logic                  hash_done_i,
    output logic [N_REQ-1:0]      done_o,
    output logic [2:0]            gnt_id_o,
    output logic                  busy_o
);

    typedef enum logic [2:0] {
        IDLE      = 3'b001,
        XFER      = 3'b010,
        WAIT_DONE = 3'b100
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         ptr_q, ptr_d, gnt_q, gnt_d;
    logic [2:0]         win;
    logic               any_vld;
    logic               xfer, fire;
    logic [N_REQ-1:0]   own;
    logic               own_vld, own_lst;

    assign xfer     = (state_q == XFER);
    assign fire     = (state_q == WAIT_DONE) && hash_done_i;
    assign any_vld  = |req_vld_i;
    assign busy_o   = (state_q != IDLE);
    assign gnt_id_o = gnt_q;

    // Scan starts just past the last owner, so that owner is considered last.
    always_comb begin
        int  idx;
        logic found;
        win   = '0;
        idx   = 0;
        found = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = (int'(ptr_q) + i) % N_REQ;
            if (!found && req_vld_i[idx]) begin
                found = 1'b1;
                win   = 3'(idx);
            end
        end
    end

    for (genvar k = 0; k < N_REQ; k++) begin : g_lane
        assign own[k]       = (gnt_q == 3'(k));
        assign req_rdy_o[k] = xfer && own[k] && dn_rdy_i;
    end

    always_comb begin
        dn_d_o        = '0;
        dn_vld_byte_o = '0;
        own_vld       = 1'b0;
        own_lst       = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (own[k]) begin
                own_vld = req_vld_i[k];
                own_lst = req_lst_i[k];
                if (xfer) begin
                    dn_d_o        = req_d_i[k*DW +: DW];
                    dn_vld_byte_o = req_vld_byte_i[k*BW +: BW];
                end
            end
        end
        dn_vld_o = xfer && own_vld;
        dn_lst_o = xfer && own_vld && own_lst;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        case (state_q)
            IDLE: begin
                if (any_vld) begin
                    gnt_d   = win;
                    ptr_d   = win;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (own_vld && own_lst && dn_rdy_i) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (hash_done_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 3'(N_REQ - 1);
            gnt_q   <= '0;
            done_o  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            done_o  <= fire ? own : '0;
        end
    end

endmodule
